// File: rtl/window_line_buffer.sv
// Sliding WxW window generator over a zero-padded raster stream.
// Optional WBUF_WINDOW_COUNT_EN adds Wbuf_WCNT, a handshaken-window counter.
module window_line_buffer #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 288,
  parameter int WINDOW_SIZE  = 3,
  parameter int DATA_WIDTH   = 24
) (
  input  logic                  Wbuf_CLK,
  input  logic                  Wbuf_RST,
  input  logic                  Wbuf_IVALID,
  input  logic [DATA_WIDTH-1:0] Wbuf_IDATA,
  output logic                  Wbuf_IRDY,
  output logic                  Wbuf_OVALID,
  input  logic                  Wbuf_ORDY,
  output logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0] Wbuf_WINDOW,
`ifdef WBUF_WINDOW_COUNT_EN
  output logic [31:0]           Wbuf_WCNT,
`endif
  output logic                  Wbuf_DNE
);

  localparam int W  = WINDOW_SIZE;
  localparam int PW = IMAGE_WIDTH + W - 1;
  localparam int PH = IMAGE_HEIGHT + W - 1;
  localparam int CW = $clog2(PW);
  localparam int RW = $clog2(PH);

  localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(W - 1);
  localparam logic [CW-1:0] COL_FILL = CW'(W - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(W - 1);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  ovalid;
  logic                  dne;
  logic                  accept;
  logic                  ohs;
  logic                  col_last;
  logic                  row_last;
  logic                  win_hit;

  logic [DATA_WIDTH-1:0] line_mem [W-1][PW];
  logic [DATA_WIDTH-1:0] win      [W][W];

  assign accept   = Wbuf_IVALID && Wbuf_IRDY;
  assign ohs      = ovalid && Wbuf_ORDY;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign win_hit  = (row >= ROW_WIN) && (col >= COL_WIN);

  assign Wbuf_IRDY   = (state != DRAIN) && (!ovalid || Wbuf_ORDY);
  assign Wbuf_OVALID = ovalid;
  assign Wbuf_DNE    = dne;

  // Line buffers: each column slot rolls up one row per accepted pixel.
  always_ff @(posedge Wbuf_CLK) begin
    if (accept) begin
      for (int r = 0; r < W - 2; r++) begin
        line_mem[r][col] <= line_mem[r+1][col];
      end
      line_mem[W-2][col] <= Wbuf_IDATA;
    end
  end

  // Window registers: shift left, load new right column from line buffers.
  always_ff @(posedge Wbuf_CLK) begin
    if (Wbuf_RST) begin
      for (int r = 0; r < W; r++) begin
        for (int c = 0; c < W; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < W; r++) begin
        for (int c = 0; c < W - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      for (int r = 0; r < W - 1; r++) begin
        win[r][W-1] <= line_mem[r][col];
      end
      win[W-1][W-1] <= Wbuf_IDATA;
    end
  end

  // Flatten window, row 0 oldest, column 0 leftmost.
  always_comb begin
    Wbuf_WINDOW = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        Wbuf_WINDOW[(r*W+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
      end
    end
  end

  // Position counters, output valid and frame FSM.
  always_ff @(posedge Wbuf_CLK) begin
    if (Wbuf_RST) begin
      state  <= FILL;
      col    <= '0;
      row    <= '0;
      ovalid <= 1'b0;
      dne    <= 1'b0;
    end else begin
      dne <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept && win_hit) begin
        ovalid <= 1'b1;
      end else if (ohs) begin
        ovalid <= 1'b0;
      end
      unique case (1'b1)
        (state == FILL): begin
          if (accept && row == ROW_WIN && col == COL_FILL) begin
            state <= STREAM;
          end
        end
        (state == STREAM): begin
          if (accept && row_last && col_last) begin
            state <= DRAIN;
          end
        end
        (state == DRAIN): begin
          if (ohs) begin
            state <= FILL;
            dne   <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef WBUF_WINDOW_COUNT_EN
  logic [31:0] wcnt;
  assign Wbuf_WCNT = wcnt;

  // Free-running count of handshaken windows since reset.
  always_ff @(posedge Wbuf_CLK) begin
    if (Wbuf_RST) begin
      wcnt <= '0;
    end else if (ohs) begin
      wcnt <= wcnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer on a 4x3 image, 3x3 window.
// Expected windows come from a direct padded-frame slicing model.
module tb_window_line_buffer;

  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int W    = 3;
  localparam int DW   = 24;
  localparam int PW   = IW + W - 1;
  localparam int PH   = IH + W - 1;
  localparam int NPIX = PW * PH;
  localparam int NWIN = IW * IH;
  localparam int WB   = W * W * DW;
  localparam int FIRST_WIN_PIX = (W - 1) * PW + (W - 1);

  typedef logic [DW-1:0] frame_t [NPIX];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ivalid = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          irdy;
  logic          ovalid;
  logic          ordy = 1'b1;
  logic [WB-1:0] window;
  logic          dne;
`ifdef WBUF_WINDOW_COUNT_EN
  logic [31:0]   wcnt;
`endif

  always #5 clk = ~clk;

  window_line_buffer #(
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH),
    .WINDOW_SIZE (W),
    .DATA_WIDTH  (DW)
  ) dut (
    .Wbuf_CLK   (clk),
    .Wbuf_RST   (rst),
    .Wbuf_IVALID(ivalid),
    .Wbuf_IDATA (idata),
    .Wbuf_IRDY  (irdy),
    .Wbuf_OVALID(ovalid),
    .Wbuf_ORDY  (ordy),
    .Wbuf_WINDOW(window),
`ifdef WBUF_WINDOW_COUNT_EN
    .Wbuf_WCNT  (wcnt),
`endif
    .Wbuf_DNE   (dne)
  );

  int            vectors = 0;
  int            errors  = 0;
  logic [WB-1:0] exp_q[$];
  bit            sb_off = 1'b0;
  bit            rand_ordy = 1'b0;
  int            stall_req = 0;
  int            stall_seen = 0;
  int            stall_left = 0;

  task automatic check(input string name, input logic [WB-1:0] act,
                       input logic [WB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] ref_window(input frame_t pix,
                                               input int wr, input int wc);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        w[(r*W+c)*DW +: DW] = pix[(wr + r) * PW + wc + c];
      end
    end
    return w;
  endfunction

  // ORDY driver: optional one-shot 5-cycle stall, else steady or random.
  always @(posedge clk) begin
    #1;
    if (stall_req != stall_seen && ovalid) begin
      stall_seen = stall_req;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      ordy = 1'b0;
      stall_left--;
    end else begin
      ordy = rand_ordy ? 1'($urandom % 2) : 1'b1;
    end
  end

  int            win_cnt = 0;
  bit            dne_exp = 1'b0;
  bit            hold_v = 1'b0;
  logic [WB-1:0] held;

  // Monitor: scoreboard pop on handshake, hold, stall and DNE checks.
  always @(negedge clk) begin
    if (rst) begin
      win_cnt = 0;
      dne_exp = 1'b0;
      hold_v  = 1'b0;
    end else begin
      check("dne", WB'(dne), WB'(dne_exp));
      dne_exp = 1'b0;
      if (hold_v) begin
        check("ovalid_hold", WB'(ovalid), WB'(1));
        check("window_hold", window, held);
        hold_v = 1'b0;
      end
      if (ovalid && !ordy) begin
        check("irdy_stall", WB'(irdy), WB'(0));
        hold_v = 1'b1;
        held   = window;
      end
      if (ovalid && ordy && !sb_off) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", window, '0);
          if (window == '0) begin
            errors++;
            $display("FAIL extra_window: got one expected none");
          end
        end else begin
          check("window", window, exp_q.pop_front());
        end
        win_cnt++;
        if (win_cnt == NWIN) begin
          dne_exp = 1'b1;
          win_cnt = 0;
        end
      end
    end
  end

  task automatic send_pix(input logic [DW-1:0] d, input bit gaps);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    if (gaps) begin
      while ($urandom % 2 == 1) begin
        ivalid = 1'b0;
        idata  = DW'($urandom);
        @(posedge clk);
        #1;
      end
    end
    ivalid = 1'b1;
    idata  = d;
    while (!acc) begin
      @(negedge clk);
      acc = irdy;
      @(posedge clk);
      #1;
      n++;
      if (n > 1000) begin
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $fatal(1, "accept timeout");
      end
    end
    ivalid = 1'b0;
    idata  = DW'($urandom);
  endtask

  task automatic send_frame(input bit rnd, input bit gaps, input int npix,
                            input bit push, input bit chk_first);
    frame_t pix;
    for (int i = 0; i < NPIX; i++) begin
      pix[i] = rnd ? DW'($urandom) : DW'(i);
    end
    if (push) begin
      for (int wr = 0; wr < IH; wr++) begin
        for (int wc = 0; wc < IW; wc++) begin
          exp_q.push_back(ref_window(pix, wr, wc));
        end
      end
    end
    for (int i = 0; i < npix; i++) begin
      send_pix(pix[i], gaps);
      if (chk_first && i == FIRST_WIN_PIX) begin
        @(negedge clk);
        check("first_ovalid", WB'(ovalid), WB'(1));
        check("first_newest", WB'(window[WB-1 -: DW]), WB'(pix[i]));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done(input bit chk_drain);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (dne) begin
        got = 1'b1;
      end else if (chk_drain) begin
        check("irdy_drain", WB'(irdy), WB'(0));
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL dne_timeout: got no dne expected dne");
    end
    check("queue_empty", WB'(exp_q.size()), WB'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got hang expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovalid", WB'(ovalid), WB'(0));
    check("rst_dne", WB'(dne), WB'(0));
    check("rst_window", window, '0);
    check("rst_irdy", WB'(irdy), WB'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    send_frame(1'b0, 1'b0, NPIX, 1'b1, 1'b1);
    wait_done(1'b1);
    send_frame(1'b0, 1'b0, NPIX, 1'b1, 1'b0);
    wait_done(1'b1);
`ifdef WBUF_WINDOW_COUNT_EN
    check("wcnt_two_frames", WB'(wcnt), WB'(2 * NWIN));
`endif

    stall_req++;
    send_frame(1'b0, 1'b0, NPIX, 1'b1, 1'b0);
    wait_done(1'b1);

    rand_ordy = 1'b1;
    send_frame(1'b0, 1'b1, NPIX, 1'b1, 1'b0);
    wait_done(1'b1);
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b1, 1'b1, NPIX, 1'b1, 1'b0);
      wait_done(1'b1);
    end
    rand_ordy = 1'b0;

    sb_off = 1'b1;
    send_frame(1'b0, 1'b0, 20, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ovalid", WB'(ovalid), WB'(0));
    check("abort_dne", WB'(dne), WB'(0));
`ifdef WBUF_WINDOW_COUNT_EN
    check("wcnt_reset", WB'(wcnt), WB'(0));
`endif
    @(posedge clk);
    #1;
    exp_q.delete();
    sb_off = 1'b0;
    rst = 1'b0;

    send_frame(1'b0, 1'b0, NPIX, 1'b1, 1'b1);
    wait_done(1'b1);
    rand_ordy = 1'b1;
    send_frame(1'b1, 1'b1, NPIX, 1'b1, 1'b0);
    wait_done(1'b1);
    rand_ordy = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 512, meaning the unpadded output image width in windows per row.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 288, meaning the unpadded output image height in window rows.
REQ-003 SHALL have parameter WINDOW_SIZE, default 3, meaning the odd window edge W (3..7).
REQ-004 SHALL have parameter DATA_WIDTH, default 24, meaning the pixel width in bits (RGB888).
REQ-005 SHALL have port Wbuf_CLK  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port Wbuf_RST  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port Wbuf_IVALID  input  1  input pixel valid.
REQ-008 SHALL have port Wbuf_IDATA  input  DATA_WIDTH  zero-padded raster pixel.
REQ-009 SHALL have port Wbuf_IRDY  output  1  pixel accepted when IVALID and IRDY.
REQ-010 SHALL have port Wbuf_OVALID  output  1  window valid.
REQ-011 SHALL have port Wbuf_ORDY  input  1  window consumed when OVALID and ORDY.
REQ-012 SHALL have port Wbuf_WINDOW  output  W*W*DATA_WIDTH  flattened window; element r*W+c at bits [(r*W+c+1)*DATA_WIDTH-1 -: DATA_WIDTH], r=0 oldest row, c=0 leftmost column.
REQ-013 SHALL have port Wbuf_DNE  output  1  one-cycle frame-complete pulse.

Function
REQ-014 SHALL accept a raster stream of PW=IMAGE_WIDTH+W-1 by PH=IMAGE_HEIGHT+W-1 padded pixels per frame.
REQ-015 SHALL store W-1 prior rows in line buffers of PW entries each plus a W x W register window shifted once per accepted pixel.
REQ-016 SHALL track input column (0..PW-1) and row (0..PH-1), column wrapping to 0 with row increment at PW-1.
REQ-017 SHALL set OVALID on the clock edge after accepting a pixel with row >= W-1 and column >= W-1 (latency 1 cycle), WINDOW then holding that pixel as element W*W-1.
REQ-018 SHALL hold OVALID and WINDOW stable until the ORDY handshake; then clear OVALID unless a new window is loaded that same edge.
REQ-019 SHALL drive IRDY = (state != DRAIN) and (!OVALID or ORDY), combinationally.
REQ-020 SHALL permit simultaneous output handshake and input accept in one cycle, sustaining one window per cycle.
REQ-021 SHALL implement FSM FILL -> STREAM when row W-1, column W-2 is accepted; STREAM -> DRAIN when pixel (PH-1, PW-1) is accepted; DRAIN -> FILL with DNE asserted for one cycle on the edge after the last window handshake.
REQ-022 SHALL emit exactly IMAGE_WIDTH*IMAGE_HEIGHT windows per frame and clear counters on DRAIN exit so the next frame starts with no idle cycle beyond DRAIN.
REQ-023 SHALL ignore IDATA whenever IVALID is low or IRDY is low; no pixel is duplicated or dropped under backpressure.

Reset
REQ-024 SHALL on Wbuf_RST force state FILL, row and column 0, OVALID 0, DNE 0, WINDOW 0; line buffer contents are not cleared.
REQ-025 SHALL abort a frame on reset mid-operation; the next accepted pixel is treated as pixel (0,0).

Configuration
REQ-026 SHALL, when macro WBUF_WINDOW_COUNT_EN is defined, add output Wbuf_WCNT (32 bits) counting handshaken windows since reset, cleared by reset only, wrapping at 2^32.
REQ-027 SHALL, without WBUF_WINDOW_COUNT_EN, omit Wbuf_WCNT and its counter entirely, with all other behaviour identical.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=3, W=3, pixel value = raster index 0..29)
REQ-028 SHALL verify: continuous IVALID, ORDY=1 -> first OVALID the cycle after index 14 is accepted, WINDOW = {0,1,2,6,7,8,12,13,14}; 12 windows total; last = {15,16,17,21,22,23,27,28,29}.
REQ-029 SHALL verify: ORDY=0 for 5 cycles at the first window -> IRDY=0 and WINDOW held at the index-14 window; resume -> no window lost, count 12.
REQ-030 SHALL verify: random IVALID gaps and ORDY gaps (50%) -> window sequence identical to REQ-028.
REQ-031 SHALL verify: frame end -> DNE high exactly one cycle after window 12 handshake; IRDY=0 during DRAIN; second frame yields identical 12 windows.
REQ-032 SHALL verify: Wbuf_RST asserted after 20 pixels -> OVALID=0 next cycle; a fresh 30-pixel frame yields correct 12 windows.
REQ-033 SHALL verify: WBUF_WINDOW_COUNT_EN defined, two frames -> Wbuf_WCNT=24; reset -> 0.
